alu_driver: RTL
===============

# alu_driver

Command-side front end for the registered ALU. Accepts tagged operation requests over a valid/ready stream, issues them to the ALU's `in0`/`in1`/`opcode` inputs and tracks the ALU's fixed pipeline latency. It captures `out`/`overflow` back into an in-order result buffer and returns tagged responses over a second valid/ready stream. Credit-based issue guarantees no ALU result is ever dropped under response backpressure.

## Interface
- `WIDTH`, 16: operand/result width; must match the ALU instance.
- `DEPTH`, 8: result buffer entries; power of two, ≥4.
- `TAG_W`, 4: request tag width.

- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  request valid.
- `cmd_ready`  out  1  request accepted when `cmd_valid & cmd_ready` at a rising edge ("fire").
- `cmd_opcode`  in  3  ALU opcode.
- `cmd_a`, `cmd_b`  in  WIDTH  operands.
- `cmd_tag`  in  TAG_W  tag returned with the result.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumed when `rsp_valid & rsp_ready` ("pop").
- `rsp_data`  out  WIDTH  result.
- `rsp_overflow`  out  1  overflow/carry bit.
- `rsp_tag`  out  TAG_W  tag of this response.
- `alu_rst_n`  out  1  ALU reset, equals `~rst`.
- `alu_in0`, `alu_in1`  out  WIDTH  to ALU `in0`/`in1`, registered.
- `alu_opcode`  out  3  to ALU `opcode`, registered.
- `alu_out`  in  WIDTH  from ALU `out`.
- `alu_overflow`  in  1  from ALU `overflow`.
- `busy`  out  1  any request in flight or buffered.

## Operation
- **Issue.** On fire, `cmd_a`/`cmd_b`/`cmd_opcode` are registered onto `alu_in0`/`alu_in1`/`alu_opcode`. Between fires these outputs hold their last value; the ALU results they produce are ignored.
- **Tracking.** A 3-stage shift pipe carries `{valid, tag, opcode}` and mirrors driver register → ALU input register → ALU output register. Stage 3 valid means `alu_out`/`alu_overflow` hold that request's result this cycle; it is written into the result FIFO at the next edge.
- **Credit.**
  - `inflight` = number of valid pipe stages, 0..3.
  - `count` = FIFO occupancy, 0..DEPTH.
  - `cmd_ready = (count + inflight < DEPTH)`, evaluated on registered state only. A same-cycle pop does not return credit.
  - The FIFO therefore never overflows. A capture when `count == DEPTH` is a design error; flag it with a simulation assertion.
- **Overflow masking.** For opcodes 101/110/111 (compares), `rsp_overflow` is forced to 0. For opcodes 000–100, `alu_overflow` is passed through.
- **FIFO.** Circular buffer of DEPTH entries with read/write pointers that wrap modulo DEPTH.
  - `rsp_*` present the head entry. `rsp_valid = (count != 0)`.
  - Simultaneous capture and pop: `count` is unchanged and both pointers advance.
  - Capture into an empty FIFO is visible on `rsp_*` the cycle after capture; there is no bypass.
- **Ordering.** Responses return strictly in issue order.
- **Busy.** `busy = (inflight != 0) | (count != 0)`.

## Timing
- Fire at edge E0:
  - `alu_*` valid after E0.
  - ALU samples at E1 and its output register updates at E2.
  - Driver captures at E3.
  - `rsp_valid` is high in the cycle after E3, i.e. 4 cycles after the fire edge.
- Throughput: one request per cycle sustained while `rsp_ready == 1` (steady occupancy is at most 3 in flight plus 1 buffered, which is below DEPTH = 8).
- **Reset (`rst` high at an edge):**
  - Pipe valids, `count` and pointers cleared.
  - `alu_in0`/`alu_in1`/`alu_opcode` = 0.
  - `rsp_data`/`rsp_tag`/`rsp_overflow` = 0.
  - `rsp_valid` = 0 and `busy` = 0.
  - `cmd_ready` = 0 while `rst` is high; it is 1 in the first cycle after `rst` deasserts.
  - `alu_rst_n` = 0 while `rst` is high.
- **Reset mid-operation:** all in-flight and buffered requests are discarded and no response is ever produced for them. The ALU is reset in the same cycles, so it returns no stale data.
- `cmd_*` must be stable while `cmd_valid` is high and `cmd_ready` is low. `rsp_*` hold stable while `rsp_valid` is high and `rsp_ready` is low.

## Test plan
- **Single add:** opcode 000, a=0x0003, b=0x0005, tag 1, fire in cycle 0 → `rsp_valid` rises in cycle 4 with data 0x0008, ovf 0, tag 1; `busy` is low once popped.
- **Overflow and mask:**
  - add 0xFFFF+0x0001 → data 0x0000, ovf 1.
  - mul 0x0100*0x0100 → data 0x0000, ovf 1.
  - opcode 101, a=9, b=2 → data 0x0001, ovf 0.
- **Backpressure:** `rsp_ready` held 0 and `cmd_valid` held 1 with tags 0..9 → exactly 8 fires, then `cmd_ready` stays 0. Release `rsp_ready` → tags 0..9 popped in order, with no loss or duplication and correct data.
- **Streaming:** 32 back-to-back subtracts with `rsp_ready` = 1 → `cmd_ready` never drops after the first fire; one response per cycle from cycle 4; FIFO pointers wrap with results intact.
- **Random `rsp_ready`:** 50% toggle over 200 random commands → scoreboard matches every response against a reference model and in-order tags.
- **Reset mid-flight:** fire 2 requests, then assert `rst` for 1 cycle at cycle 2 → no `rsp_valid` for them, `busy` = 0, `cmd_ready` = 1 the cycle after release. A new add then completes normally at +4 cycles.

Source files
------------

// File: rtl/alu_driver_if.sv
// alu_driver_if: command and response streams between a requester and the
// ALU driver.
//
// Handshake semantics (both streams): a transfer happens at a rising clock
// edge where valid and ready are both high. Once valid is raised, the sender
// keeps valid high and the payload stable until that transfer. Ready may be
// raised or dropped at any time and never depends on the same-cycle valid.
//
// Signals:
//   cmd_valid/cmd_ready          request stream handshake
//   cmd_opcode, cmd_a, cmd_b     ALU opcode and operands
//   cmd_tag                      tag echoed back with the result
//   rsp_valid/rsp_ready          response stream handshake
//   rsp_data, rsp_overflow       result and overflow/carry bit
//   rsp_tag                      tag of the request that produced this result
//
// Modports: master = requester, slave = the ALU driver.
interface alu_driver_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_opcode;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [TAG_W-1:0] cmd_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_overflow;
  logic [TAG_W-1:0] rsp_tag;

  modport master (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_tag, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_overflow, rsp_tag
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_tag, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_overflow, rsp_tag
  );
endinterface

// File: rtl/alu_driver.sv
// alu_driver: front end for a registered ALU with a fixed two-register
// latency (input register, output register).
//
// Accepted requests are registered onto alu_in0/alu_in1/alu_opcode, tracked
// through a 3-stage {valid, tag, opcode} pipe that mirrors
// driver reg -> ALU input reg -> ALU output reg, captured into an in-order
// result FIFO and returned on the response stream. Requests are only
// accepted while FIFO occupancy plus in-flight requests is below DEPTH, so
// a result arriving from the ALU always has a free slot.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   bus (alu_driver_if.slave)   command/response streams
//   alu_rst_n                   ALU reset (= ~rst)
//   alu_in0, alu_in1, alu_opcode  registered ALU inputs
//   alu_out, alu_overflow       ALU result
//   busy                        any request in flight or buffered
//
// WIDTH and TAG_W must match the bus interface instance and the ALU.
module alu_driver #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  alu_driver_if.slave      bus,
  output logic             alu_rst_n,
  output logic [WIDTH-1:0] alu_in0,
  output logic [WIDTH-1:0] alu_in1,
  output logic [2:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_overflow,
  output logic             busy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Pipe index 0 = driver register, 1 = ALU input reg, 2 = ALU output reg.
  logic [2:0]       pipe_valid;
  logic [TAG_W-1:0] pipe_tag [3];
  logic [2:0]       pipe_op  [3];

  logic [WIDTH-1:0] mem_data [DEPTH];
  logic             mem_ovf  [DEPTH];
  logic [TAG_W-1:0] mem_tag  [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    inflight;

  logic fire;
  logic pop;
  logic capture;
  logic capture_ovf;

  assign inflight = CW'(pipe_valid[0]) + CW'(pipe_valid[1]) + CW'(pipe_valid[2]);

  // Credit uses registered state only; a pop in this cycle frees its slot
  // for issue decisions starting next cycle.
  assign bus.cmd_ready = ~rst & ((count + inflight) < DEPTH_C);
  assign fire          = bus.cmd_valid & bus.cmd_ready;

  assign bus.rsp_valid = (count != '0);
  assign pop           = bus.rsp_valid & bus.rsp_ready;
  assign capture       = pipe_valid[2];

  // Compare opcodes (101/110/111) have no meaningful overflow.
  assign capture_ovf = (pipe_op[2] >= 3'b101) ? 1'b0 : alu_overflow;

  // Head entry, forced to zero when empty so the response payload is clean
  // out of reset.
  assign bus.rsp_data     = bus.rsp_valid ? mem_data[rd_ptr] : '0;
  assign bus.rsp_overflow = bus.rsp_valid ? mem_ovf[rd_ptr]  : 1'b0;
  assign bus.rsp_tag      = bus.rsp_valid ? mem_tag[rd_ptr]  : '0;

  assign busy      = (inflight != '0) | (count != '0);
  assign alu_rst_n = ~rst;

  // Control state and ALU drive registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid <= '0;
      alu_in0    <= '0;
      alu_in1    <= '0;
      alu_opcode <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      pipe_valid <= {pipe_valid[1:0], fire};
      if (fire) begin
        alu_in0    <= bus.cmd_a;
        alu_in1    <= bus.cmd_b;
        alu_opcode <= bus.cmd_opcode;
      end
      if (capture) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({capture, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage: qualified by pipe_valid / count, so no reset needed.
  always_ff @(posedge clk) begin
    pipe_tag[0] <= bus.cmd_tag;
    pipe_op[0]  <= bus.cmd_opcode;
    pipe_tag[1] <= pipe_tag[0];
    pipe_op[1]  <= pipe_op[0];
    pipe_tag[2] <= pipe_tag[1];
    pipe_op[2]  <= pipe_op[1];
    if (capture & ~rst) begin
      mem_data[wr_ptr] <= alu_out;
      mem_ovf[wr_ptr]  <= capture_ovf;
      mem_tag[wr_ptr]  <= pipe_tag[2];
    end
  end

  // Credit issue makes this unreachable; firing means the credit math broke.
  property no_capture_when_full;
    @(posedge clk) disable iff (rst) !(capture && (count == DEPTH_C));
  endproperty
  assert property (no_capture_when_full);

endmodule
